// File: rtl/mm2s_rd_ctrl.sv
// MM2S read-request scheduler: splits one transfer command into 4 KB-safe bursts, issues them
// only when the data FIFO has room for every beat, and tracks returning beats to completion.
module mm2s_rd_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_OUTST  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ADDR_W-1:0]                cmd_addr,
  input  logic [LEN_W-1:0]                 cmd_beats,
  output logic                             ar_valid,
  input  logic                             ar_ready,
  output logic [ADDR_W-1:0]                ar_addr,
  output logic [7:0]                       ar_len,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  input  logic                             fill_beat,
  input  logic                             fill_last,
  output logic                             busy,
  output logic                             done,
  output logic                             proto_err
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OST_W = $clog2(MAX_OUTST + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCalc  = 2'd1;
  localparam logic [1:0] StIssue = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [7:0]        len_m1_q, len_m1_d;
  logic [LVL_W-1:0]  inflight_q, inflight_d;
  logic [OST_W-1:0]  outst_q, outst_d;
  logic              armed_q, armed_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [31:0] burst_len, page_left, calc_len, fill_sum;
  logic        credit_ok, ar_hs, beat_err, last_err, last_ok;

  assign burst_len = 32'(len_m1_q) + 32'd1;
  assign page_left = (32'd4096 - 32'(addr_q[11:0])) >> OFF_W;

  always_comb begin
    calc_len = 32'(remaining_q);
    if (calc_len > MAX_BURST) calc_len = MAX_BURST;
    if (calc_len > page_left) calc_len = page_left;
  end

  // Once raised, ar_valid is held by armed_q so a later credit drop cannot retract it.
  assign credit_ok = (burst_len + 32'(fifo_level) + 32'(inflight_q) <= FIFO_DEPTH) &&
                     (32'(outst_q) < MAX_OUTST);
  assign ar_valid  = (state_q == StIssue) && (armed_q || credit_ok);
  assign ar_hs     = ar_valid && ar_ready;
  assign ar_addr   = addr_q;
  assign ar_len    = len_m1_q;

  assign cmd_ready = rst_n && (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign proto_err = err_q;

  // A beat landing in the same cycle as a handshake is netted against the new burst.
  assign fill_sum = 32'(inflight_q) + (ar_hs ? burst_len : 32'd0);
  assign beat_err = fill_beat && (fill_sum == 32'd0);
  assign last_err = fill_beat && fill_last && (outst_q == '0);
  assign last_ok  = fill_beat && fill_last && !last_err;

  always_comb begin
    inflight_d = LVL_W'((fill_beat && !beat_err) ? fill_sum - 32'd1 : fill_sum);
    outst_d    = outst_q + OST_W'(ar_hs) - OST_W'(last_ok);
    err_d      = err_q | beat_err | last_err;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    len_m1_d    = len_m1_q;
    armed_d     = armed_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr & ~ADDR_W'(BYTES - 1);
          remaining_d = cmd_beats;
          state_d     = (cmd_beats != '0) ? StCalc : StDrain;
        end
      end
      StCalc: begin
        len_m1_d = 8'(calc_len - 32'd1);
        state_d  = StIssue;
      end
      StIssue: begin
        if (ar_hs) begin
          addr_d      = addr_q + ADDR_W'(burst_len << OFF_W);
          remaining_d = remaining_q - LEN_W'(burst_len);
          armed_d     = 1'b0;
          state_d     = (remaining_q == LEN_W'(burst_len)) ? StDrain : StCalc;
        end else if (ar_valid) begin
          armed_d = 1'b1;
        end
      end
      StDrain: begin
        // done is registered; the FSM lingers one cycle so busy covers the done pulse.
        if (done_q) begin
          state_d = StIdle;
        end else if ((inflight_q == '0) && (outst_q == '0)) begin
          done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      len_m1_q    <= '0;
      inflight_q  <= '0;
      outst_q     <= '0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      len_m1_q    <= len_m1_d;
      inflight_q  <= inflight_d;
      outst_q     <= outst_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_mm2s_rd_ctrl.sv
// Randomized bench for mm2s_rd_ctrl: a burst-plan model, a memory/FIFO emulator and a per-cycle
// compare against the DUT, plus directed scenarios pinned with literal expectations.
module tb_mm2s_rd_ctrl;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 64;
  localparam int LEN_W      = 16;
  localparam int MAX_BURST  = 16;
  localparam int FIFO_DEPTH = 256;
  localparam int MAX_OUTST  = 4;
  localparam int BYTES      = DATA_W / 8;
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

  logic              clk, rst_n;
  logic              cmd_valid, cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_beats;
  logic              ar_valid, ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [LVL_W-1:0]  fifo_level;
  logic              fill_beat, fill_last;
  logic              busy, done, proto_err;

  mm2s_rd_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST),
    .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTST(MAX_OUTST)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .ar_addr(ar_addr), .ar_len(ar_len), .fifo_level(fifo_level), .fill_beat(fill_beat),
    .fill_last(fill_last), .busy(busy), .done(done), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Knobs set by the scenario code, applied by step().
  bit          cmd_v = 0;
  logic [31:0] cmd_a = '0;
  int          cmd_b = 0;
  int          rdy_mode = 1;   // 0 random, 1 always, 2 never
  bit          lvl_rand = 0;
  int          lvl_fix = 0;
  int          ret_budget = 0;
  bit          ret_always = 0;
  bit          spur = 0;

  // Model state.
  logic [31:0] exp_addr[$];
  int          exp_len[$];
  int          mem_q[$];
  logic [31:0] log_addr[$];
  int          log_len[$];
  int          m_inflight = 0, m_outst = 0;
  bit          m_busy = 0, m_err = 0, m_quiet_prev = 0;
  bit          prev_hold = 0;
  logic [31:0] prev_addr;
  logic [7:0]  prev_len;
  int          cyc = 0, acc_cyc = 0, done_cyc = 0, busy_cnt = 0, av_cnt = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected burst list for a command, from the splitting rules.
  task automatic plan(input logic [31:0] addr, input int beats);
    logic [31:0] a;
    int r, l, pg;
    a = addr & ~32'(BYTES - 1);
    r = beats;
    while (r > 0) begin
      pg = (4096 - int'(a % 4096)) / BYTES;
      l = r;
      if (l > MAX_BURST) l = MAX_BURST;
      if (l > pg) l = pg;
      exp_addr.push_back(a);
      exp_len.push_back(l);
      a = a + 32'(l * BYTES);
      r -= l;
    end
  endtask

  task automatic model_reset();
    exp_addr.delete(); exp_len.delete(); mem_q.delete();
    m_inflight = 0; m_outst = 0; m_busy = 0; m_err = 0; m_quiet_prev = 0;
    prev_hold = 0; cmd_v = 0; spur = 0;
  endtask

  task automatic step();
    bit fb, fl, hs, quiet;
    int blen;
    @(negedge clk);
    cyc++;
    cmd_valid = cmd_v;
    cmd_addr  = cmd_a;
    cmd_beats = 16'(cmd_b);
    case (rdy_mode)
      0:       ar_ready = 1'($urandom % 2);
      1:       ar_ready = 1'b1;
      default: ar_ready = 1'b0;
    endcase
    if (lvl_rand)
      fifo_level = ($urandom % 2) ? LVL_W'($urandom_range(0, 16))
                                  : LVL_W'($urandom_range(0, FIFO_DEPTH - m_inflight));
    else
      fifo_level = LVL_W'(lvl_fix);
    fb = 0; fl = 0;
    if (spur) begin
      fb = 1; spur = 0;
    end else if (mem_q.size() > 0 && ret_budget > 0 && (ret_always || $urandom % 4 != 0)) begin
      fb = 1; fl = (mem_q[0] == 1);
    end
    fill_beat = fb;
    fill_last = fl;
    #1;
    chk("busy", busy, m_busy);
    chk("cmd_ready", cmd_ready, !m_busy);
    chk("done", done, m_quiet_prev);
    chk("proto_err", proto_err, m_err);
    if (prev_hold) begin
      chk("ar_hold_valid", ar_valid, 1);
      chk("ar_hold_addr", ar_addr, prev_addr);
      chk("ar_hold_len", ar_len, prev_len);
    end
    if (exp_addr.size() == 0) begin
      chk("ar_unexpected", ar_valid, 0);
    end else if (ar_valid) begin
      chk("ar_addr", ar_addr, exp_addr[0]);
      chk("ar_len", ar_len, 64'(exp_len[0] - 1));
      if (!prev_hold)
        chk("ar_credit", (int'(ar_len) + 1 + int'(fifo_level) + m_inflight <= FIFO_DEPTH) &&
                         (m_outst < MAX_OUTST), 1);
    end
    if (busy) busy_cnt++;
    if (ar_valid) av_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end

    // Update model for the coming clock edge.
    quiet = m_busy && exp_addr.size() == 0 && m_inflight == 0 && m_outst == 0 && !m_quiet_prev;
    hs = ar_valid && ar_ready;
    blen = 0;
    if (hs) begin
      log_addr.push_back(ar_addr);
      log_len.push_back(int'(ar_len));
      if (exp_len.size() > 0) begin
        blen = exp_len[0];
        void'(exp_addr.pop_front());
        void'(exp_len.pop_front());
        mem_q.push_back(blen);
      end
    end
    if (fb) begin
      if (m_inflight + blen == 0) m_err = 1;
      else m_inflight = m_inflight + blen - 1;
      if (mem_q.size() > 0) begin
        mem_q[0]--;
        if (mem_q[0] == 0) void'(mem_q.pop_front());
        ret_budget--;
      end
    end else begin
      m_inflight += blen;
    end
    if (fb && fl) begin
      if (m_outst == 0) m_err = 1;
      else m_outst--;
    end
    if (hs) m_outst++;
    if (m_quiet_prev) m_busy = 0;
    m_quiet_prev = quiet;
    if (cmd_v && !m_busy) begin
      plan(cmd_a, cmd_b);
      m_busy = 1;
      cmd_v = 0;
      acc_cyc = cyc;
    end
    prev_hold = ar_valid && !ar_ready;
    prev_addr = ar_addr;
    prev_len  = ar_len;
  endtask

  task automatic do_reset();
    fill_beat = 0; fill_last = 0; cmd_valid = 0; ar_ready = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((cmd_v || m_busy) && n < budget) begin step(); n++; end
    chk({name, "_timeout"}, (cmd_v || m_busy), 0);
    if (cmd_v || m_busy) do_reset();
  endtask

  task automatic start(input logic [31:0] a, input int b);
    cmd_a = a; cmd_b = b; cmd_v = 1;
    log_addr.delete(); log_len.delete();
    busy_cnt = 0; av_cnt = 0; done_cnt = 0;
  endtask

  initial begin
    int n;
    rst_n = 0; cmd_valid = 0; cmd_addr = '0; cmd_beats = '0; ar_ready = 0;
    fifo_level = '0; fill_beat = 0; fill_last = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_ar_valid", ar_valid, 0);
    chk("rst_ar_addr", ar_addr, 0);
    chk("rst_ar_len", ar_len, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_proto_err", proto_err, 0);
    rst_n = 1;

    // Basic three-burst split.
    rdy_mode = 1; lvl_fix = 0; ret_budget = 1 << 30; ret_always = 1;
    start(32'h1000, 40);
    wait_idle("basic", 300);
    chk("basic_n_ar", log_addr.size(), 3);
    if (log_addr.size() == 3) begin
      chk("basic_a0", log_addr[0], 32'h1000); chk("basic_l0", log_len[0], 15);
      chk("basic_a1", log_addr[1], 32'h1080); chk("basic_l1", log_len[1], 15);
      chk("basic_a2", log_addr[2], 32'h1100); chk("basic_l2", log_len[2], 7);
    end
    chk("basic_done_cnt", done_cnt, 1);

    // 4 KB boundary split.
    start(32'h0FF0, 4);
    wait_idle("split", 100);
    chk("split_n_ar", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("split_a0", log_addr[0], 32'h0FF0); chk("split_l0", log_len[0], 1);
      chk("split_a1", log_addr[1], 32'h1000); chk("split_l1", log_len[1], 1);
    end

    // Credit stall, release, then held request.
    rdy_mode = 2; lvl_fix = 250;
    start(32'h2000, 16);
    repeat (8) step();
    chk("stall_no_ar", av_cnt, 0);
    lvl_fix = 0;
    n = 0;
    do begin step(); n++; end while (!ar_valid && n < 2);
    chk("credit_release", ar_valid, 1);
    lvl_fix = 250;
    repeat (5) step();
    chk("held_addr", ar_addr, 32'h2000);
    chk("held_len", ar_len, 15);
    rdy_mode = 1; lvl_fix = 0;
    wait_idle("stall", 200);

    // Outstanding cap.
    ret_budget = 0;
    start(32'h5000, 256);
    repeat (30) step();
    chk("outst_cap", log_addr.size(), 4);
    ret_budget = 16;
    n = 0;
    while (log_addr.size() < 5 && n < 40) begin step(); n++; end
    chk("outst_5th", log_addr.size(), 5);
    if (log_addr.size() >= 5) chk("outst_5th_addr", log_addr[4], 32'h5200);
    ret_budget = 1 << 30;
    wait_idle("outst", 600);

    // Zero-beat command.
    start(32'h7000, 0);
    wait_idle("zero", 20);
    chk("zero_busy_cycles", busy_cnt, 2);
    chk("zero_no_ar", av_cnt, 0);
    chk("zero_done_lat", done_cyc - acc_cyc, 2);

    // Spurious beat in IDLE.
    spur = 1;
    step();
    repeat (3) step();
    chk("spur_sticky", proto_err, 1);

    // Reset after the second AR.
    ret_budget = 0;
    start(32'h3000, 64);
    n = 0;
    while (log_addr.size() < 2 && n < 30) begin step(); n++; end
    step();
    rst_n = 0;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_ar_valid", ar_valid, 0);
    chk("mid_rst_ar_addr", ar_addr, 0);
    chk("mid_rst_ar_len", ar_len, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_proto_err", proto_err, 0);
    do_reset();
    ret_budget = 1 << 30;
    start(32'h4000, 8);
    wait_idle("post_rst", 100);
    chk("post_rst_done", done_cnt, 1);

    // Randomized commands.
    rdy_mode = 0; lvl_rand = 1; ret_always = 0;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom % 2) a[11:0] = 12'($urandom_range(12'hF80, 12'hFFF));
      start(a, $urandom_range(0, 100));
      wait_idle("rand", 3000);
      chk("rand_done_cnt", done_cnt, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
